// File: rtl/fan_speed_ctrl.sv
// Temperature-driven fan controller: sample handshake, 4-zone FSM with hysteresis, speed output.
// Define FAN_SOFT_RAMP_EN to ramp speed toward the target in STEP increments every RAMP_DIV cycles.
`timescale 1ns/1ps

module fan_speed_ctrl #(
    parameter logic [7:0]  T_LOW    = 8'd25,
    parameter logic [7:0]  T_MID    = 8'd35,
    parameter logic [7:0]  T_CRIT   = 8'd45,
    parameter logic [7:0]  HYST     = 8'd2,
    parameter logic [7:0]  SPD_LOW  = 8'd96,
    parameter logic [7:0]  SPD_HIGH = 8'd192,
    parameter logic [7:0]  STEP     = 8'd4,
    parameter logic [15:0] RAMP_DIV = 16'd50000
) (
    input  logic       arst,
    input  logic       clk,
    input  logic [7:0] temp,
    input  logic       temp_valid,
    output logic       temp_ready,
    input  logic       enable,
    output logic [7:0] speed,
    output logic       fan_on,
    output logic       alarm
);

    localparam int unsigned TW = 8;
    localparam int unsigned SW = 8;

    typedef enum logic [1:0] {
        ZONE_OFF  = 2'd0,
        ZONE_LOW  = 2'd1,
        ZONE_HIGH = 2'd2,
        ZONE_CRIT = 2'd3
    } zone_t;

    // Highest zone whose entry threshold is at or below t.
    function automatic zone_t zone_of(input logic [TW-1:0] t);
        zone_t z;
        if (t >= T_CRIT)      z = ZONE_CRIT;
        else if (t >= T_MID)  z = ZONE_HIGH;
        else if (t >= T_LOW)  z = ZONE_LOW;
        else                  z = ZONE_OFF;
        return z;
    endfunction

    function automatic logic [SW-1:0] target_of(input zone_t z);
        logic [SW-1:0] s;
        case (z)
            ZONE_LOW:  s = SPD_LOW;
            ZONE_HIGH: s = SPD_HIGH;
            ZONE_CRIT: s = 8'hFF;
            default:   s = 8'h00;
        endcase
        return s;
    endfunction

    zone_t          zone;
    zone_t          zone_nxt;
    zone_t          zone_up_c;
    zone_t          zone_dn_c;
    logic [TW-1:0]  sample;
    logic           accept_c;
    logic           eval_c;
    logic [TW:0]    hyst_sum_c;
    logic [TW-1:0]  hyst_sat_c;
    logic [SW-1:0]  target;
    logic [SW-1:0]  target_nxt;
    logic           alarm_nxt;
    logic [SW-1:0]  speed_nxt_c;

    assign accept_c = temp_valid & temp_ready;
    // The cycle after an acceptance is the evaluate cycle; temp_ready is low exactly then.
    assign eval_c   = ~temp_ready;

    // Handshake: ready drops for one cycle after each acceptance.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            temp_ready <= 1'b1;
            sample     <= '0;
        end else begin
            temp_ready <= ~accept_c;
            if (accept_c) sample <= temp;
        end
    end

    // Downward decisions use temp+HYST, saturated so 254/255 don't wrap to a low zone.
    assign hyst_sum_c = {1'b0, sample} + {1'b0, HYST};
    assign hyst_sat_c = hyst_sum_c[TW] ? {TW{1'b1}} : hyst_sum_c[TW-1:0];
    assign zone_up_c  = zone_of(sample);
    assign zone_dn_c  = zone_of(hyst_sat_c);

    // Zone state register.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) zone <= ZONE_OFF;
        else       zone <= zone_nxt;
    end

    // Zone next-state and the zone-derived outputs.
    always_comb begin
        zone_nxt   = zone;
        target_nxt = target;
        alarm_nxt  = alarm;
        if (!enable) begin
            zone_nxt = ZONE_OFF;
        end else if (eval_c) begin
            if (zone_up_c > zone)       zone_nxt = zone_up_c;
            else if (zone_dn_c < zone)  zone_nxt = zone_dn_c;
        end
        target_nxt = target_of(zone_nxt);
        alarm_nxt  = (zone_nxt == ZONE_CRIT);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            target <= '0;
            alarm  <= 1'b0;
        end else begin
            target <= target_nxt;
            alarm  <= alarm_nxt;
        end
    end

`ifdef FAN_SOFT_RAMP_EN
    logic [15:0]   ramp_cnt;
    logic          tick_c;
    logic [SW:0]   up_sum_c;
    logic [SW:0]   dn_lim_c;
    logic [SW-1:0] step_c;

    // Free-running tick divider; deliberately not restarted on target change.
    assign tick_c = (ramp_cnt == RAMP_DIV - 16'd1);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst)       ramp_cnt <= '0;
        else if (tick_c) ramp_cnt <= '0;
        else             ramp_cnt <= ramp_cnt + 16'd1;
    end

    // One STEP toward the target, computed 9-bit and clamped so it never overshoots or wraps.
    assign up_sum_c = {1'b0, speed} + {1'b0, STEP};
    assign dn_lim_c = {1'b0, target} + {1'b0, STEP};

    always_comb begin
        step_c = speed;
        if (speed < target) begin
            step_c = (up_sum_c >= {1'b0, target}) ? target : up_sum_c[SW-1:0];
        end else if (speed > target) begin
            step_c = ({1'b0, speed} <= dn_lim_c) ? target : SW'(speed - STEP);
        end
    end

    always_comb begin
        speed_nxt_c = speed;
        if (zone_nxt == ZONE_CRIT) speed_nxt_c = 8'hFF;
        else if (tick_c)           speed_nxt_c = step_c;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{STEP, RAMP_DIV};

    // CRIT lands together with alarm; all other zones follow the registered target a cycle later.
    always_comb begin
        speed_nxt_c = target;
        if (zone_nxt == ZONE_CRIT) speed_nxt_c = 8'hFF;
    end
`endif

    // Speed and fan_on; fan_on lags speed by one cycle.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            speed  <= '0;
            fan_on <= 1'b0;
        end else begin
            speed  <= speed_nxt_c;
            fan_on <= (speed != '0);
        end
    end

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Self-checking bench for fan_speed_ctrl (RAMP_DIV=4): vector table, hand-timed corner cases,
// and random samples checked against a zone-level reference model.
`timescale 1ns/1ps

module tb_fan_speed_ctrl;

`ifdef FAN_SOFT_RAMP_EN
    localparam int SETTLE = 290;
    localparam int NRAND  = 25;
`else
    localparam int SETTLE = 6;
    localparam int NRAND  = 120;
`endif

    logic       arst;
    logic       clk;
    logic [7:0] temp;
    logic       temp_valid;
    logic       temp_ready;
    logic       enable;
    logic [7:0] speed;
    logic       fan_on;
    logic       alarm;

    fan_speed_ctrl #(.RAMP_DIV(16'd4)) dut (
        .arst       (arst),
        .clk        (clk),
        .temp       (temp),
        .temp_valid (temp_valid),
        .temp_ready (temp_ready),
        .enable     (enable),
        .speed      (speed),
        .fan_on     (fan_on),
        .alarm      (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b0;
        temp_valid = 1'b0;
        enable = 1'b1;
        temp = 8'd0;
        repeat (2) tick();
        arst = 1'b1;
    endtask

    // Returns one tick after the acceptance edge, i.e. inside the evaluate cycle.
    task automatic send(input logic [7:0] t);
        int w = 0;
        while (!temp_ready && w < 10) begin
            tick();
            w++;
        end
        if (!temp_ready) chk("ready_timeout", 0, 1);
        temp = t;
        temp_valid = 1'b1;
        tick();
        temp_valid = 1'b0;
    endtask

    // Reference model at zone level: thresholds 25/35/45, hysteresis 2.
    function automatic int zone_of(input int t);
        if (t >= 45) return 3;
        if (t >= 35) return 2;
        if (t >= 25) return 1;
        return 0;
    endfunction

    function automatic int model_next(input int cur, input int t, input bit en);
        int up, dn, s;
        if (!en) return 0;
        s  = (t + 2 > 255) ? 255 : t + 2;
        up = zone_of(t);
        dn = zone_of(s);
        if (up > cur) return up;
        if (dn < cur) return dn;
        return cur;
    endfunction

    function automatic int speed_of(input int z);
        int tbl[4] = '{0, 96, 192, 255};
        return tbl[z];
    endfunction

    typedef struct {
        logic [7:0] t;
        logic       en;
        int         exp_speed;
        logic       exp_alarm;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, last, n, mzone;
        logic [7:0] rt;
        bit ren;

        tbl[0]  = '{8'd30,  1'b1, 96,  1'b0};
        tbl[1]  = '{8'd40,  1'b1, 192, 1'b0};
        tbl[2]  = '{8'd34,  1'b1, 192, 1'b0};
        tbl[3]  = '{8'd32,  1'b1, 96,  1'b0};
        tbl[4]  = '{8'd50,  1'b1, 255, 1'b1};
        tbl[5]  = '{8'd43,  1'b1, 255, 1'b1};
        tbl[6]  = '{8'd42,  1'b1, 192, 1'b0};
        tbl[7]  = '{8'd23,  1'b1, 96,  1'b0};
        tbl[8]  = '{8'd22,  1'b1, 0,   1'b0};
        tbl[9]  = '{8'd24,  1'b1, 0,   1'b0};
        tbl[10] = '{8'd255, 1'b1, 255, 1'b1};
        tbl[11] = '{8'd35,  1'b0, 0,   1'b0};
        tbl[12] = '{8'd35,  1'b1, 192, 1'b0};
        tbl[13] = '{8'd0,   1'b1, 0,   1'b0};
        tbl[14] = '{8'd25,  1'b1, 96,  1'b0};
        tbl[15] = '{8'd253, 1'b1, 255, 1'b1};
        tbl[16] = '{8'd254, 1'b1, 255, 1'b1};

        // Reset values, then acceptance on the very first edge after release.
        arst = 1'b0;
        temp_valid = 1'b0;
        enable = 1'b1;
        temp = 8'd0;
        repeat (3) tick();
        chk("rst_speed", int'(speed), 0);
        chk("rst_fan_on", int'(fan_on), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_ready", int'(temp_ready), 1);
        arst = 1'b1;
        temp = 8'd30;
        temp_valid = 1'b1;
        tick();
        temp_valid = 1'b0;
        chk("first_accept_ready", int'(temp_ready), 0);
        tick();
        chk("eval_ready_back", int'(temp_ready), 1);
        chk("low_speed_e1", int'(speed), 0);
`ifndef FAN_SOFT_RAMP_EN
        tick();
        chk("low_speed_e2", int'(speed), 96);
        chk("low_fan_on_e2", int'(fan_on), 0);
        tick();
        chk("low_fan_on_e3", int'(fan_on), 1);
`else
        // Ramp from 0 to LOW: +4 every 4 cycles, exactly 96 at the end.
        do_reset();
        send(8'd26);
        prev = int'(speed);
        last = 0;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (int'(speed) != prev) begin
                n++;
                chk("ramp_step", int'(speed) - prev, 4);
                if (n > 1) chk("ramp_period", c - last, 4);
                last = c;
                prev = int'(speed);
            end
        end
        chk("ramp_final", int'(speed), 96);
        chk("ramp_count", n, 24);
`endif

        // CRIT entry: alarm and full speed appear together, ramp or not.
        do_reset();
        send(8'd50);
        chk("crit_eval_alarm", int'(alarm), 0);
        chk("crit_eval_speed", int'(speed), 0);
        tick();
        chk("crit_alarm", int'(alarm), 1);
        chk("crit_speed", int'(speed), 255);

        // Vector table applied as a sequence.
        do_reset();
        foreach (tbl[i]) begin
            enable = tbl[i].en;
            send(tbl[i].t);
            repeat (SETTLE) tick();
            chk($sformatf("vec%0d_speed", i), int'(speed), tbl[i].exp_speed);
            chk($sformatf("vec%0d_alarm", i), int'(alarm), int'(tbl[i].exp_alarm));
            chk($sformatf("vec%0d_fan_on", i), int'(fan_on), int'(tbl[i].exp_speed != 0));
        end

        // Enable drop in HIGH with back-to-back valid: ready keeps toggling, fan goes off.
        do_reset();
        send(8'd40);
        repeat (SETTLE) tick();
        chk("high_before_drop", int'(speed), 192);
        enable = 1'b0;
        temp = 8'd40;
        temp_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("b2b_ready%0d", k), int'(temp_ready), (k % 2 == 0) ? 0 : 1);
`ifndef FAN_SOFT_RAMP_EN
            if (k == 1) chk("drop_speed_fast", int'(speed), 0);
`endif
        end
        temp_valid = 1'b0;
        repeat (SETTLE) tick();
        chk("drop_speed", int'(speed), 0);
        chk("drop_alarm", int'(alarm), 0);
        enable = 1'b1;

        // Reset asserted mid-evaluate from CRIT.
        do_reset();
        send(8'd50);
        repeat (SETTLE) tick();
        send(8'd20);
        #2 arst = 1'b0;
        #1;
        chk("arst_eval_speed", int'(speed), 0);
        chk("arst_eval_alarm", int'(alarm), 0);
        chk("arst_eval_fan_on", int'(fan_on), 0);
        chk("arst_eval_ready", int'(temp_ready), 1);

        // Reset asserted while the speed is moving.
        do_reset();
        send(8'd30);
        repeat (9) tick();
        #2 arst = 1'b0;
        #1;
        chk("arst_ramp_speed", int'(speed), 0);
        chk("arst_ramp_fan_on", int'(fan_on), 0);
        chk("arst_ramp_ready", int'(temp_ready), 1);
        tick();
        arst = 1'b1;
        send(8'd20);
        repeat (SETTLE) tick();
        chk("post_arst_zone_off", int'(speed), 0);

        // Random samples against the zone-level model.
        do_reset();
        mzone = 0;
        for (int i = 0; i < NRAND; i++) begin
            ren = ($urandom_range(0, 7) != 0);
            rt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(15, 55));
            enable = ren;
            mzone = model_next(mzone, int'(rt), ren);
            send(rt);
            repeat (SETTLE) tick();
            chk($sformatf("rnd%0d_t%0d_speed", i, rt), int'(speed), speed_of(mzone));
            chk($sformatf("rnd%0d_t%0d_alarm", i, rt), int'(alarm), int'(mzone == 3));
            chk($sformatf("rnd%0d_t%0d_fan_on", i, rt), int'(fan_on), int'(mzone != 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
